// File: rtl/zipbus_watchdog.sv
// Wishbone pipelined-bus watchdog between the CPU master port and the interconnect.
// Passes requests through combinationally, tracks outstanding requests and aborts hung cycles.
module zipbus_watchdog #(
    parameter int unsigned AW      = 30,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned LGDEPTH = 5
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [AW-1:0]   i_wb_addr,
    input  logic [DW-1:0]   i_wb_data,
    input  logic [DW/8-1:0] i_wb_sel,
    output logic            o_wb_stall,
    output logic            o_wb_ack,
    output logic            o_wb_err,
    output logic [DW-1:0]   o_wb_data,
    output logic            o_m_cyc,
    output logic            o_m_stb,
    output logic            o_m_we,
    output logic [AW-1:0]   o_m_addr,
    output logic [DW-1:0]   o_m_data,
    output logic [DW/8-1:0] o_m_sel,
    input  logic            i_m_stall,
    input  logic            i_m_ack,
    input  logic            i_m_err,
    input  logic [DW-1:0]   i_m_data,
    output logic            o_timeout,
    output logic [AW-1:0]   o_fault_addr
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [LGDEPTH-1:0] MAX_OUT    = '1;
    localparam logic [TW-1:0]      TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StAbort
    } state_t;

    state_t             r_state, w_state_next;
    logic [LGDEPTH-1:0] r_outstanding, w_outstanding_next;
    logic [TW-1:0]      r_timer, w_timer_next;
    logic [AW-1:0]      r_last_addr;
    logic [AW-1:0]      r_fault_addr;
    logic               r_timeout;

    logic w_full;
    logic w_aborted;
    logic w_pending;
    logic w_accept;
    logic w_resp;
    logic w_progress;
    logic w_abort;

    assign w_full    = (r_outstanding == MAX_OUT);
    assign w_aborted = (r_state == StAbort);
    assign w_pending = (r_outstanding != '0);

    // Reset gates the control outputs combinationally so they drop without a clock.
    assign o_m_cyc    = i_reset_n && i_wb_cyc && !w_aborted;
    assign o_m_stb    = i_reset_n && i_wb_stb && !w_full && !w_aborted;
    assign o_m_we     = i_wb_we;
    assign o_m_addr   = i_wb_addr;
    assign o_m_data   = i_wb_data;
    assign o_m_sel    = i_wb_sel;
    assign o_wb_data  = i_m_data;
    assign o_wb_stall = w_aborted || i_m_stall || w_full;

    assign w_accept   = o_m_stb && !i_m_stall;
    assign w_resp     = (i_m_ack || i_m_err) && w_pending && !w_aborted;
    assign w_progress = w_accept || w_resp;

    assign o_wb_ack     = i_reset_n && i_m_ack && w_pending && !w_aborted;
    assign o_wb_err     = i_reset_n && ((i_m_err && w_pending && !w_aborted) || r_timeout);
    assign o_timeout    = r_timeout;
    assign o_fault_addr = r_fault_addr;

    always_comb begin
        w_outstanding_next = r_outstanding;
        if (!i_wb_cyc || w_aborted) begin
            w_outstanding_next = '0;
        end else if (w_accept && !w_resp) begin
            w_outstanding_next = r_outstanding + LGDEPTH'(1);
        end else if (!w_accept && w_resp) begin
            w_outstanding_next = r_outstanding - LGDEPTH'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_abort      = 1'b0;
        case (r_state)
            StIdle: begin
                w_timer_next = '0;
                if (i_wb_cyc) begin
                    w_state_next = StBusy;
                end
            end
            StBusy: begin
                if (!i_wb_cyc) begin
                    w_state_next = StIdle;
                    w_timer_next = '0;
                end else if (w_progress) begin
                    w_timer_next = '0;
                end else if (r_timer >= TIMER_LAST) begin
                    // Timer holds here; the abort leaves BUSY so it never wraps.
                    w_abort      = 1'b1;
                    w_state_next = StAbort;
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            StAbort: begin
                w_timer_next = '0;
                if (!i_wb_cyc) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_timer_next = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= StIdle;
            r_outstanding <= '0;
            r_timer       <= '0;
            r_timeout     <= 1'b0;
            r_last_addr   <= '0;
            r_fault_addr  <= '0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_outstanding_next;
            r_timer       <= w_timer_next;
            r_timeout     <= w_abort;
            if (w_accept) begin
                r_last_addr <= i_wb_addr;
            end
            if (w_abort) begin
                r_fault_addr <= r_last_addr;
            end
        end
    end

endmodule

// File: tb/tb_zipbus_watchdog.sv
// Self-checking bench for zipbus_watchdog: scripted bus cycles, read-data scoreboard on acks.
module tb_zipbus_watchdog;

    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;

    logic            i_clk;
    logic            i_reset_n;
    logic            i_wb_cyc, i_wb_stb, i_wb_we;
    logic [AW-1:0]   i_wb_addr;
    logic [DW-1:0]   i_wb_data;
    logic [DW/8-1:0] i_wb_sel;
    logic            o_wb_stall, o_wb_ack, o_wb_err;
    logic [DW-1:0]   o_wb_data;
    logic            o_m_cyc, o_m_stb, o_m_we;
    logic [AW-1:0]   o_m_addr;
    logic [DW-1:0]   o_m_data;
    logic [DW/8-1:0] o_m_sel;
    logic            i_m_stall, i_m_ack, i_m_err;
    logic [DW-1:0]   i_m_data;
    logic            o_timeout;
    logic [AW-1:0]   o_fault_addr;

    int n_cmp = 0;
    int n_err = 0;
    int n_ack = 0;
    int ack_base;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] mon_exp;

    zipbus_watchdog #(
        .AW(AW),
        .DW(DW),
        .TIMEOUT(16),
        .LGDEPTH(2)
    ) u_dut (
        .i_clk(i_clk),
        .i_reset_n(i_reset_n),
        .i_wb_cyc(i_wb_cyc),
        .i_wb_stb(i_wb_stb),
        .i_wb_we(i_wb_we),
        .i_wb_addr(i_wb_addr),
        .i_wb_data(i_wb_data),
        .i_wb_sel(i_wb_sel),
        .o_wb_stall(o_wb_stall),
        .o_wb_ack(o_wb_ack),
        .o_wb_err(o_wb_err),
        .o_wb_data(o_wb_data),
        .o_m_cyc(o_m_cyc),
        .o_m_stb(o_m_stb),
        .o_m_we(o_m_we),
        .o_m_addr(o_m_addr),
        .o_m_data(o_m_data),
        .o_m_sel(o_m_sel),
        .i_m_stall(i_m_stall),
        .i_m_ack(i_m_ack),
        .i_m_err(i_m_err),
        .i_m_data(i_m_data),
        .o_timeout(o_timeout),
        .o_fault_addr(o_fault_addr)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #100000;
        $display("FAIL sim_time_limit: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge i_clk);
    endtask

    // Every forwarded ack must match the oldest pushed read-data expectation.
    always @(negedge i_clk) begin
        if (i_reset_n && o_wb_ack) begin
            if (sb.size() == 0) begin
                check_eq("stray_ack_fwd", {63'd0, o_wb_ack}, 64'd0);
            end else begin
                mon_exp = sb.pop_front();
                check_eq("sb_rdata", {32'd0, o_wb_data}, {32'd0, mon_exp});
                n_ack++;
            end
        end
    end

    initial begin
        i_reset_n = 1'b0;
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = 1'b0;
        i_wb_addr = '0;
        i_wb_data = '0;
        i_wb_sel  = '0;
        i_m_stall = 1'b0;
        i_m_ack   = 1'b0;
        i_m_err   = 1'b0;
        i_m_data  = '0;
        #3;
        check_eq("rst_m_cyc", {63'd0, o_m_cyc}, 64'd0);
        check_eq("rst_m_stb", {63'd0, o_m_stb}, 64'd0);
        check_eq("rst_timeout", {63'd0, o_timeout}, 64'd0);
        check_eq("rst_wb_err", {63'd0, o_wb_err}, 64'd0);
        check_eq("rst_fault", {34'd0, o_fault_addr}, 64'd0);
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        step();
        step();
        i_reset_n = 1'b1;

        // Single read, ack three cycles after acceptance.
        step();
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_addr = 30'h10;
        i_wb_data = 32'hCAFEF00D;
        i_wb_sel  = 4'hF;
        sb.push_back(32'hDEADBEEF);
        sample();
        check_eq("t1_m_cyc", {63'd0, o_m_cyc}, 64'd1);
        check_eq("t1_m_stb", {63'd0, o_m_stb}, 64'd1);
        check_eq("t1_stall", {63'd0, o_wb_stall}, 64'd0);
        check_eq("t1_addr", {34'd0, o_m_addr}, 64'h10);
        check_eq("t1_wdata", {32'd0, o_m_data}, 64'hCAFEF00D);
        step();
        i_wb_stb = 1'b0;
        sample();
        check_eq("t1_no_early_ack", {63'd0, o_wb_ack}, 64'd0);
        step();
        step();
        i_m_ack  = 1'b1;
        i_m_data = 32'hDEADBEEF;
        sample();
        check_eq("t1_ack", {63'd0, o_wb_ack}, 64'd1);
        check_eq("t1_rdata", {32'd0, o_wb_data}, 64'hDEADBEEF);
        step();
        i_m_ack  = 1'b0;
        i_wb_cyc = 1'b0;
        sample();
        check_eq("t1_no_timeout", {63'd0, o_timeout}, 64'd0);
        check_eq("t1_no_err", {63'd0, o_wb_err}, 64'd0);

        // One accepted request never answered: abort after 16 idle cycles.
        step();
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_addr = 30'h1234;
        step();
        i_wb_stb  = 1'b0;
        i_wb_addr = 30'h3FFF;
        for (int c = 1; c <= 16; c++) begin
            sample();
            check_eq($sformatf("t2_err_early_c%0d", c), {63'd0, o_wb_err}, 64'd0);
            step();
        end
        sample();
        check_eq("t2_err", {63'd0, o_wb_err}, 64'd1);
        check_eq("t2_timeout", {63'd0, o_timeout}, 64'd1);
        check_eq("t2_m_cyc", {63'd0, o_m_cyc}, 64'd0);
        check_eq("t2_stall", {63'd0, o_wb_stall}, 64'd1);
        check_eq("t2_fault", {34'd0, o_fault_addr}, 64'h1234);
        step();
        i_m_ack  = 1'b1;
        i_m_data = 32'h0BAD0BAD;
        sample();
        check_eq("t2_late_ack", {63'd0, o_wb_ack}, 64'd0);
        check_eq("t2_err_pulse_end", {63'd0, o_wb_err}, 64'd0);
        check_eq("t2_timeout_end", {63'd0, o_timeout}, 64'd0);
        check_eq("t2_m_cyc_held", {63'd0, o_m_cyc}, 64'd0);
        step();
        i_m_ack  = 1'b0;
        i_wb_cyc = 1'b0;

        // Pipelined burst of four with one stall cycle, then a stray ack.
        ack_base = n_ack;
        step();
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_addr = 30'h100;
        sb.push_back(32'h11110000);
        step();
        i_wb_addr = 30'h101;
        i_m_ack   = 1'b1;
        i_m_data  = 32'h11110000;
        sb.push_back(32'h11110001);
        step();
        i_wb_addr = 30'h102;
        i_m_stall = 1'b1;
        i_m_data  = 32'h11110001;
        sample();
        check_eq("t3_stall", {63'd0, o_wb_stall}, 64'd1);
        step();
        i_m_stall = 1'b0;
        i_m_ack   = 1'b0;
        sb.push_back(32'h11110002);
        step();
        i_wb_addr = 30'h103;
        i_m_ack   = 1'b1;
        i_m_data  = 32'h11110002;
        sb.push_back(32'h11110003);
        step();
        i_wb_stb = 1'b0;
        i_m_data = 32'h11110003;
        step();
        i_m_ack = 1'b0;
        sample();
        check_eq("t3_ack_count", ack_base + 4, n_ack);
        check_eq("t3_sb_empty", sb.size(), 0);
        step();
        i_m_ack  = 1'b1;
        i_m_data = 32'hBAD;
        sample();
        check_eq("t5_stray_ack", {63'd0, o_wb_ack}, 64'd0);
        step();
        i_m_ack  = 1'b0;
        i_wb_cyc = 1'b0;

        // Outstanding limit of three: the fourth request is held off.
        step();
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_addr = 30'h200;
        sb.push_back(32'hA0);
        step();
        i_wb_addr = 30'h201;
        sb.push_back(32'hA1);
        step();
        i_wb_addr = 30'h202;
        sb.push_back(32'hA2);
        step();
        i_wb_addr = 30'h203;
        sample();
        check_eq("t4_full_stall", {63'd0, o_wb_stall}, 64'd1);
        check_eq("t4_full_stb", {63'd0, o_m_stb}, 64'd0);
        step();
        i_m_ack  = 1'b1;
        i_m_data = 32'hA0;
        sample();
        check_eq("t4_ack0", {63'd0, o_wb_ack}, 64'd1);
        check_eq("t4_still_full", {63'd0, o_m_stb}, 64'd0);
        step();
        i_m_ack = 1'b0;
        sb.push_back(32'hA3);
        sample();
        check_eq("t4_release_stall", {63'd0, o_wb_stall}, 64'd0);
        check_eq("t4_release_stb", {63'd0, o_m_stb}, 64'd1);
        step();
        i_wb_stb = 1'b0;
        i_m_ack  = 1'b1;
        i_m_data = 32'hA1;
        step();
        i_m_data = 32'hA2;
        step();
        i_m_data = 32'hA3;
        step();
        i_m_ack  = 1'b0;
        i_wb_cyc = 1'b0;
        sample();
        check_eq("t4_sb_empty", sb.size(), 0);

        // Asynchronous reset mid-burst with two requests outstanding.
        step();
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_addr = 30'h300;
        step();
        i_wb_addr = 30'h301;
        step();
        #2;
        i_reset_n = 1'b0;
        i_m_ack   = 1'b1;
        #1;
        check_eq("t6_async_m_cyc", {63'd0, o_m_cyc}, 64'd0);
        check_eq("t6_async_m_stb", {63'd0, o_m_stb}, 64'd0);
        check_eq("t6_async_ack", {63'd0, o_wb_ack}, 64'd0);
        check_eq("t6_fault_cleared", {34'd0, o_fault_addr}, 64'd0);
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_m_ack  = 1'b0;
        step();
        step();
        i_reset_n = 1'b1;
        step();
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_addr = 30'h400;
        sb.push_back(32'h12345678);
        step();
        i_wb_stb = 1'b0;
        i_m_ack  = 1'b1;
        i_m_data = 32'h12345678;
        sample();
        check_eq("t6_post_ack", {63'd0, o_wb_ack}, 64'd1);
        check_eq("t6_post_rdata", {32'd0, o_wb_data}, 64'h12345678);
        step();
        i_m_ack  = 1'b0;
        i_wb_cyc = 1'b0;
        sample();
        check_eq("t6_no_timeout", {63'd0, o_timeout}, 64'd0);

        check_eq("total_acks", n_ack, 10);
        check_eq("final_sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
